// File: rtl/imem_refill_ctrl.sv
// imem_refill_ctrl: Imem block-read requester that turns L1 I-cache misses into one-cycle fill writes.
// Optional next-block prefetch buffer is enabled by defining IMEM_PREFETCH_EN.
module imem_refill_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              miss_req_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              miss_busy_o,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              err_timeout_o,
    output logic              ren_o,
    output logic [ADDR_W-1:0] block_address_o,
    input  logic              ready_i,
    input  logic [LINE_W-1:0] dout_i
);
`ifdef IMEM_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, REQ, FILL, GAP, PREF} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, FILL, GAP} state_t;
`endif

    localparam bit         TO_EN  = TIMEOUT != 0;
    localparam logic [7:0] TO_VAL = (TIMEOUT > 255) ? 8'hFF : 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ba_q, ba_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_W-1:0] fill_data_q, fill_data_d;
    logic              ren_q, ren_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cnt_inc;
    logic              timeout_hit;

    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timeout_hit = TO_EN && (cnt_q == TO_VAL);

`ifdef IMEM_PREFETCH_EN
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [LINE_W-1:0] pf_data_q, pf_data_d;
    logic              pf_go_q, pf_go_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              req_any;
    logic [ADDR_W-1:0] req_addr;
    logic              pf_hit;

    // A miss held during a prefetch takes precedence over the live request lines
    assign req_any  = miss_req_i | pend_q;
    assign req_addr = pend_q ? pend_addr_q : miss_addr_i;
    assign pf_hit   = pf_valid_q && (req_addr == pf_addr_q);
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ba_q        <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            ren_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef IMEM_PREFETCH_EN
            pf_valid_q  <= 1'b0;
            pf_addr_q   <= '0;
            pf_data_q   <= '0;
            pf_go_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            ren_q       <= ren_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef IMEM_PREFETCH_EN
            pf_valid_q  <= pf_valid_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
            pf_go_q     <= pf_go_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ba_d        = ba_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        ren_d       = ren_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef IMEM_PREFETCH_EN
        pf_valid_d  = pf_valid_q;
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;
        pf_go_d     = pf_go_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef IMEM_PREFETCH_EN
                if (req_any) begin
                    pend_d = 1'b0;
                    err_d  = 1'b0;
                    addr_d = req_addr;
                    if (pf_hit) begin
                        fill_data_d = pf_data_q;
                        fill_addr_d = req_addr;
                        pf_valid_d  = 1'b0;
                        state_d     = FILL;
                    end else begin
                        ba_d    = req_addr;
                        ren_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
`else
                if (miss_req_i) begin
                    addr_d  = miss_addr_i;
                    ba_d    = miss_addr_i;
                    ren_d   = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
`endif
            end
            REQ: begin
                if (ready_i) begin
                    fill_data_d = dout_i;
                    fill_addr_d = addr_q;
                    ren_d       = 1'b0;
                    state_d     = FILL;
                end else if (timeout_hit) begin
                    ren_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FILL: begin
`ifdef IMEM_PREFETCH_EN
                pf_go_d = 1'b1;
`endif
                state_d = GAP;
            end
            GAP: begin
`ifdef IMEM_PREFETCH_EN
                if (pf_go_q) begin
                    pf_go_d = 1'b0;
                    ba_d    = fill_addr_q + ADDR_W'(1);
                    ren_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = PREF;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
`ifdef IMEM_PREFETCH_EN
            PREF: begin
                if (miss_req_i && !pend_q) begin
                    pend_d      = 1'b1;
                    pend_addr_d = miss_addr_i;
                end
                if (ready_i) begin
                    pf_valid_d = 1'b1;
                    pf_addr_d  = ba_q;
                    pf_data_d  = dout_i;
                    ren_d      = 1'b0;
                    state_d    = GAP;
                end else if (timeout_hit) begin
                    pf_valid_d = 1'b0;
                    ren_d      = 1'b0;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_busy_o     = state_q != IDLE;
        fill_valid_o    = state_q == FILL;
        fill_addr_o     = fill_addr_q;
        fill_data_o     = fill_data_q;
        err_timeout_o   = err_q;
        ren_o           = ren_q;
        block_address_o = ba_q;
    end
endmodule

// File: tb/tb_imem_refill_ctrl.sv
// tb_imem_refill_ctrl: directed and randomized refill transactions checked against a cycle-timing reference model.
module tb_imem_refill_ctrl;
    localparam int AW = 16;
    localparam int LW = 128;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_req = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic          ready = 1'b0;
    logic [LW-1:0] dout = '0;
    logic          miss_busy, fill_valid, err_timeout, ren;
    logic [AW-1:0] fill_addr, block_address;
    logic [LW-1:0] fill_data;

    int total = 0;
    int passed = 0;
    logic [LW-1:0] last_data = '0;

    imem_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_ni(rst_n), .miss_req_i(miss_req), .miss_addr_i(miss_addr),
        .miss_busy_o(miss_busy), .fill_valid_o(fill_valid), .fill_addr_o(fill_addr),
        .fill_data_o(fill_data), .err_timeout_o(err_timeout), .ren_o(ren),
        .block_address_o(block_address), .ready_i(ready), .dout_i(dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected behaviour: ren/block_address from the accept edge, fill pulse on the cycle after
    // ready, one GAP cycle, then IDLE; miss_req in GAP and miss_addr changes in REQ are ignored.
    task automatic miss(input logic [AW-1:0] a, input int lat, input logic [LW-1:0] d);
        chk("idle_busy", miss_busy, 0);
        miss_req = 1'b1;
        miss_addr = a;
        step();
        miss_req = 1'b0;
        miss_addr = AW'($urandom);
        chk("acc_ren", ren, 1);
        chk("acc_ba", block_address, a);
        chk("acc_busy", miss_busy, 1);
        chk("acc_err", err_timeout, 0);
        for (int i = 0; i < lat; i++) begin
            step();
            miss_addr = AW'($urandom);
            chk("req_ren", ren, 1);
            chk("req_ba", block_address, a);
            chk("req_fv", fill_valid, 0);
        end
        ready = 1'b1;
        dout = d;
        step();
        ready = 1'b0;
        dout = rnd_line();
        chk("fill_fv", fill_valid, 1);
        chk("fill_ren", ren, 0);
        chk("fill_addr", fill_addr, a);
        chk("fill_data", fill_data, d);
        last_data = d;
        step();
        chk("gap_fv", fill_valid, 0);
        chk("gap_ren", ren, 0);
        chk("gap_busy", miss_busy, 1);
        miss_req = 1'b1;
        miss_addr = AW'($urandom);
        step();
        miss_req = 1'b0;
        chk("post_busy", miss_busy, 0);
        chk("post_ren", ren, 0);
    endtask

    initial begin
        #2;
        chk("rst_ren", ren, 0);
        chk("rst_busy", miss_busy, 0);
        chk("rst_fv", fill_valid, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ba", block_address, 0);
        chk("rst_faddr", fill_addr, 0);
        chk("rst_fdata", fill_data, 0);
        step();
        rst_n = 1'b1;
        step();

        miss(16'h0004, 10, 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0004);

        // ready pulsed while idle must not be captured
        ready = 1'b1;
        dout = rnd_line();
        step();
        ready = 1'b0;
        chk("spur_fv", fill_valid, 0);
        chk("spur_busy", miss_busy, 0);
        chk("spur_data", fill_data, last_data);
        step();
        chk("spur_data2", fill_data, last_data);

        for (int i = 0; i < 32; i++) miss(AW'(i), int'($urandom_range(0, 15)), rnd_line());

        // timeout: ren stays high for TO+1 cycles of REQ, then drops with err set
        miss_req = 1'b1;
        miss_addr = 16'h0BAD;
        step();
        miss_req = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step();
            chk("to_ren_hi", ren, 1);
            chk("to_err_lo", err_timeout, 0);
        end
        step();
        chk("to_ren_lo", ren, 0);
        chk("to_err", err_timeout, 1);
        chk("to_fv", fill_valid, 0);
        chk("to_busy", miss_busy, 1);
        step();
        chk("to_idle", miss_busy, 0);
        chk("to_fv2", fill_valid, 0);
        step();
        step();
        chk("to_sticky", err_timeout, 1);
        chk("to_data", fill_data, last_data);
        miss(16'h0123, 3, rnd_line());

        // async reset in the middle of a request
        miss_req = 1'b1;
        miss_addr = 16'h0004;
        step();
        miss_req = 1'b0;
        step();
        chk("ar_ren_pre", ren, 1);
        chk("ar_ba_pre", block_address, 16'h0004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ren", ren, 0);
        chk("ar_busy", miss_busy, 0);
        chk("ar_ba", block_address, 0);
        chk("ar_fv", fill_valid, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("ar_fv_held", fill_valid, 0);
        chk("ar_fdata", fill_data, 0);
        #3;
        rst_n = 1'b1;
        step();
        miss(16'h0005, 4, rnd_line());

        for (int i = 0; i < 20; i++) miss(AW'($urandom), int'($urandom_range(0, TO)), rnd_line());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
